vga_vblank_arbiter: RTL

VGA_VBLANK_ARBITER -- requirements
Module: vga_vblank_arbiter

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_vblank_arbiter_rr_pick.sv | 33 +++
 rtl/vga_vblank_arbiter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing constants, vblank arbiter defaults,
// FSM state encoding and the round-robin index helper.
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int ARB_NUM_REQ   = 4;
    localparam int ARB_MAX_BURST = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_t;

    // (base + off) mod n, valid while base < n and off <= n.
    function automatic int unsigned rr_index(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        int unsigned sum;
        sum = base + off;
        return (sum >= n) ? (sum - n) : sum;
    endfunction

endpackage

// File: rtl/vga_vblank_arbiter_rr_pick.sv
// Combinational round-robin selector: first asserted request at or after the
// pointer, wrapping once around the requester ring.
module rr_pick
    import vga_pkg::*;
#(
    parameter int NUM_REQ = ARB_NUM_REQ,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_pick,
    output logic               o_valid
);

    logic [PTR_W-1:0] w_idx;

    // Walk the ring from the pointer; the first requester seen wins.
    always_comb begin
        o_pick  = '0;
        o_valid = 1'b0;
        w_idx   = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_W'(rr_index(32'(i_ptr), k, NUM_REQ));
            if (!o_valid && i_req[w_idx]) begin
                o_pick[w_idx] = 1'b1;
                o_valid       = 1'b1;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/vga_vblank_arbiter.sv
// Vertical-blank write arbiter: grants game-logic requesters round-robin bursts
// into the sprite/palette register file, only while vblank is high.
module vga_vblank_arbiter
    import vga_pkg::*;
#(
    parameter int NUM_REQ   = ARB_NUM_REQ,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 24,
    parameter int MAX_BURST = ARB_MAX_BURST
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      vblank,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W-1:0]         wr_data,
    output logic [15:0]               frame_cnt,
    output logic [NUM_REQ-1:0]        missed
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST);

    arb_state_t          r_state;
    logic                r_vblank_d;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_cur;
    logic [CNT_W-1:0]    r_burst;
    logic [NUM_REQ-1:0]  r_gnt;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic [15:0]         r_frame_cnt;
    logic [NUM_REQ-1:0]  r_missed;

    logic                w_vb_rise;
    logic                w_vb_fall;
    logic                w_xfer;
    logic                w_pick_valid;
    logic [NUM_REQ-1:0]  w_pick;
    logic [PTR_W-1:0]    w_pick_idx;
    logic [PTR_W-1:0]    w_next_ptr;
    logic [CNT_W-1:0]    w_burst_inc;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_pick  (w_pick),
        .o_valid (w_pick_valid)
    );

    // The edge register resets high so a blank already in progress is not a rise.
    assign w_vb_rise   = vblank & ~r_vblank_d;
    assign w_vb_fall   = ~vblank & r_vblank_d;
    assign w_xfer      = (r_state == ST_XFER) & vblank & req[r_cur] & r_gnt[r_cur];
    assign w_burst_inc = r_burst + CNT_W'(1);
    assign w_next_ptr  = PTR_W'(rr_index(32'(r_cur), 32'd1, NUM_REQ));

    // Encode the one-hot pick into the owner index.
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = PTR_W'(i);
            end else begin
                w_pick_idx = w_pick_idx;
            end
        end
    end

    // Route the current owner's address and data slices to the write port.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_cur == PTR_W'(i)) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*DATA_W +: DATA_W];
            end else begin
                w_sel_addr = w_sel_addr;
            end
        end
    end

    // Arbitration FSM with edge tracking, frame counting and missed reporting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_vblank_d  <= 1'b1;
            r_ptr       <= '0;
            r_cur       <= '0;
            r_burst     <= '0;
            r_gnt       <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_frame_cnt <= 16'd0;
            r_missed    <= '0;
        end else begin
            r_vblank_d <= vblank;
            r_wr_en    <= 1'b0;
            r_missed   <= w_vb_fall ? (req & ~r_gnt) : '0;
            if (w_vb_rise) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
                r_frame_cnt <= r_frame_cnt;
            end
            case (r_state)
                ST_IDLE: begin
                    r_gnt <= '0;
                    if (w_vb_rise) begin
                        r_state <= ST_ARB;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ARB: begin
                    if (!vblank) begin
                        r_state <= ST_IDLE;
                    end else if (w_pick_valid) begin
                        r_gnt   <= w_pick;
                        r_cur   <= w_pick_idx;
                        r_burst <= '0;
                        r_state <= ST_XFER;
                    end else begin
                        r_state <= ST_ARB;
                    end
                end
                ST_XFER: begin
                    // End of blank wins over a pending word, so nothing is written late.
                    if (!vblank) begin
                        r_gnt   <= '0;
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_IDLE;
                    end else if (w_xfer) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= w_sel_addr;
                        r_wr_data <= w_sel_data;
                        r_burst   <= w_burst_inc;
                        if (w_burst_inc == BURST_LAST) begin
                            r_gnt   <= '0;
                            r_ptr   <= w_next_ptr;
                            r_state <= ST_ARB;
                        end else begin
                            r_state <= ST_XFER;
                        end
                    end else begin
                        r_gnt   <= '0;
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_ARB;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign frame_cnt = r_frame_cnt;
    assign missed    = r_missed;

endmodule
